// File: rtl/axi4_lite_cmd_arbiter_pkg.sv
// Package: axi4_lite_cmd_arbiter_pkg
// Types shared by the command arbiter: the transaction FSM state encoding
// and the control part of the latched command (direction + owner index).
package axi4_lite_cmd_arbiter_pkg;

    // Wide enough for the largest supported requester count (8).
    localparam int REQ_IDX_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WR_ADDR_DATA = 3'd1,
        ST_WR_RESP      = 3'd2,
        ST_RD_ADDR      = 3'd3,
        ST_RD_DATA      = 3'd4,
        ST_RSP          = 3'd5
    } arb_state_t;

    typedef struct packed {
        logic                 we;
        logic [REQ_IDX_W-1:0] idx;
    } cmd_ctl_t;

endpackage

// File: rtl/axi4_lite_if_pkg.sv
// Package: axi4_lite_if_pkg
// Shared AXI4-Lite protocol constants for the subsystem. Holds the
// BRESP/RRESP response codes that every master and slave agree on.
package axi4_lite_if_pkg;

    localparam logic [1:0] AXI4_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI4_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI4_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI4_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_lite_if.sv
// Interface: axi4_lite_if
// AXI4-Lite bundle (AW, W, B, AR, R channels).
//   mst_port : master view (drives VALIDs, addresses, write data, BREADY/RREADY)
//   slv_port : slave view (drives READYs and responses)
// Handshake rule on every channel: a transfer happens on the rising edge where
// VALID and READY are both high; once VALID is raised the source keeps VALID and
// its payload unchanged until that edge.
interface axi4_lite_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                awvalid;
    logic                awready;
    logic [ADDR_W-1:0]   awaddr;
    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                bvalid;
    logic                bready;
    logic [1:0]          bresp;
    logic                arvalid;
    logic                arready;
    logic [ADDR_W-1:0]   araddr;
    logic                rvalid;
    logic                rready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;

    modport mst_port (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slv_port (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_cmd_arbiter_rr_arbiter.sv
// Module: axi4_lite_cmd_arbiter_rr_arbiter
// Round-robin grant: combinational choice of the first requester after the
// last granted one (modulo NUM_REQ), with a registered last-grant pointer that
// advances only when the grant is actually taken.
// Ports:
//   i_clk, i_sync_rst : clock, synchronous active-high reset
//   i_req             : request vector
//   i_grant_accept    : the current grant is consumed this cycle
//   o_grant           : one-hot grant (zero when no request)
//   o_grant_idx       : index of the granted requester
//   o_grant_any       : at least one request is present
module axi4_lite_cmd_arbiter_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_sync_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_grant_accept,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_grant_any
);
    logic [IDX_W-1:0] last_q;
    int               cand;

    // Scan offsets 1..NUM_REQ so the last winner is checked last.
    always_comb begin
        o_grant_idx = last_q;
        o_grant_any = 1'b0;
        cand        = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = (int'(last_q) + off) % NUM_REQ;
            if (!o_grant_any && i_req[IDX_W'(cand)]) begin
                o_grant_any = 1'b1;
                o_grant_idx = IDX_W'(cand);
            end
        end
        o_grant = '0;
        if (o_grant_any) begin
            o_grant[o_grant_idx] = 1'b1;
        end
    end

    // Pointer starts at the last index so requester 0 wins first after reset.
    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            last_q <= IDX_W'(NUM_REQ - 1);
        end else if (i_grant_accept && o_grant_any) begin
            last_q <= o_grant_idx;
        end
    end
endmodule

// File: rtl/axi4_lite_cmd_arbiter.sv
// Module: axi4_lite_cmd_arbiter
// Shares one AXI4-Lite master port between NUM_REQ register-access requesters
// with round-robin arbitration and exactly one transaction in flight.
// Optional feature macro: AXI4_LITE_CMD_ARB_ADDR_CHECK_EN -- when defined, a
// granted command outside [ADDR_WIN_BASE, ADDR_WIN_BASE+ADDR_WIN_SIZE) is
// answered locally with SLVERR and never reaches the bus.
// Ports:
//   i_clk, i_sync_rst   : clock, synchronous active-high reset
//   i_req_valid/we/addr/wdata/wstrb : per-requester command (flattened vectors)
//   o_req_ready         : one-hot accept pulse, combinational in IDLE
//   o_rsp_valid         : one-hot 1-cycle response pulse to the issuing requester
//   o_rsp_rdata         : read data (0 for writes), o_rsp_resp : BRESP/RRESP
//   o_dbg_state         : current FSM state
//   o_dbg_grant_in_win  : granted command address lies in the legal window
//   if_m_axi4_lite      : shared AXI4-Lite master port
// Requester handshake: a command transfers on the edge where i_req_valid[n] and
// o_req_ready[n] are both high; an unserved requester holds its command stable.
module axi4_lite_cmd_arbiter
    import axi4_lite_cmd_arbiter_pkg::*;
    import axi4_lite_if_pkg::*;
#(
    parameter int NUM_REQ                  = 2,
    parameter int AXI4_LITE_ADDR_BIT_WIDTH = 32,
    parameter int AXI4_LITE_DATA_BIT_WIDTH = 32,
    parameter logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0] ADDR_WIN_BASE = '0,
    parameter int ADDR_WIN_SIZE            = 16
) (
    input  logic                                     i_clk,
    input  logic                                     i_sync_rst,
    input  logic [NUM_REQ-1:0]                       i_req_valid,
    output logic [NUM_REQ-1:0]                       o_req_ready,
    input  logic [NUM_REQ-1:0]                       i_req_we,
    input  logic [NUM_REQ*AXI4_LITE_ADDR_BIT_WIDTH-1:0]     i_req_addr,
    input  logic [NUM_REQ*AXI4_LITE_DATA_BIT_WIDTH-1:0]     i_req_wdata,
    input  logic [NUM_REQ*(AXI4_LITE_DATA_BIT_WIDTH/8)-1:0] i_req_wstrb,
    output logic [NUM_REQ-1:0]                       o_rsp_valid,
    output logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]      o_rsp_rdata,
    output logic [1:0]                               o_rsp_resp,
    output logic [2:0]                               o_dbg_state,
    output logic                                     o_dbg_grant_in_win,
    axi4_lite_if.mst_port                            if_m_axi4_lite
);
    localparam int ADDR_W = AXI4_LITE_ADDR_BIT_WIDTH;
    localparam int DATA_W = AXI4_LITE_DATA_BIT_WIDTH;
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic               grant_accept;
    logic               cmd_legal;

    int                 sel;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [ADDR_W-1:0]  sel_off;
    logic [DATA_W-1:0]  sel_wdata;
    logic [STRB_W-1:0]  sel_wstrb;
    logic               grant_in_win;

    arb_state_t         state_q;
    cmd_ctl_t           cmd_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [STRB_W-1:0]  wstrb_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [1:0]         resp_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic               awvalid_q;
    logic               wvalid_q;
    logic               bready_q;
    logic               arvalid_q;
    logic               rready_q;
    logic               aw_done;
    logic               w_done;

    axi4_lite_cmd_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .i_clk          (i_clk),
        .i_sync_rst     (i_sync_rst),
        .i_req          (i_req_valid),
        .i_grant_accept (grant_accept),
        .o_grant        (grant),
        .o_grant_idx    (grant_idx),
        .o_grant_any    (grant_any)
    );

    // Mux out the granted requester's command and test it against the window.
    always_comb begin
        sel          = int'(grant_idx);
        sel_we       = i_req_we[grant_idx];
        sel_addr     = i_req_addr[sel*ADDR_W +: ADDR_W];
        sel_wdata    = i_req_wdata[sel*DATA_W +: DATA_W];
        sel_wstrb    = i_req_wstrb[sel*STRB_W +: STRB_W];
        sel_off      = sel_addr - ADDR_WIN_BASE;
        grant_in_win = (sel_addr >= ADDR_WIN_BASE) && (sel_off < ADDR_W'(ADDR_WIN_SIZE));
    end

`ifdef AXI4_LITE_CMD_ARB_ADDR_CHECK_EN
    assign cmd_legal = grant_in_win;
`else
    assign cmd_legal = 1'b1;
`endif

    assign grant_accept = (state_q == ST_IDLE) && grant_any;
    assign o_req_ready  = grant_accept ? grant : '0;

    // A channel counts as done once its VALID has dropped or handshakes now.
    assign aw_done = !awvalid_q || if_m_axi4_lite.awready;
    assign w_done  = !wvalid_q  || if_m_axi4_lite.wready;

    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= '0;
            rsp_valid_q <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_accept) begin
                        cmd_q.we  <= sel_we;
                        cmd_q.idx <= REQ_IDX_W'(grant_idx);
                        addr_q    <= sel_addr;
                        wdata_q   <= sel_wdata;
                        wstrb_q   <= sel_wstrb;
                        if (!cmd_legal) begin
                            resp_q      <= AXI4_RESP_SLVERR;
                            rdata_q     <= '0;
                            rsp_valid_q <= NUM_REQ'(1) << grant_idx;
                            state_q     <= ST_RSP;
                        end else if (sel_we) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= ST_WR_ADDR_DATA;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WR_ADDR_DATA: begin
                    if (if_m_axi4_lite.awready) awvalid_q <= 1'b0;
                    if (if_m_axi4_lite.wready)  wvalid_q  <= 1'b0;
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (if_m_axi4_lite.bvalid) begin
                        bready_q    <= 1'b0;
                        resp_q      <= if_m_axi4_lite.bresp;
                        rsp_valid_q <= NUM_REQ'(1) << cmd_q.idx;
                        state_q     <= ST_RSP;
                    end
                end
                ST_RD_ADDR: begin
                    if (if_m_axi4_lite.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (if_m_axi4_lite.rvalid) begin
                        rready_q    <= 1'b0;
                        rdata_q     <= if_m_axi4_lite.rdata;
                        resp_q      <= if_m_axi4_lite.rresp;
                        rsp_valid_q <= NUM_REQ'(1) << cmd_q.idx;
                        state_q     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    rsp_valid_q <= '0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_rsp_valid        = rsp_valid_q;
    assign o_rsp_rdata        = cmd_q.we ? '0 : rdata_q;
    assign o_rsp_resp         = resp_q;
    assign o_dbg_state        = state_q;
    assign o_dbg_grant_in_win = grant_in_win;

    assign if_m_axi4_lite.awvalid = awvalid_q;
    assign if_m_axi4_lite.awaddr  = addr_q;
    assign if_m_axi4_lite.wvalid  = wvalid_q;
    assign if_m_axi4_lite.wdata   = wdata_q;
    assign if_m_axi4_lite.wstrb   = wstrb_q;
    assign if_m_axi4_lite.bready  = bready_q;
    assign if_m_axi4_lite.arvalid = arvalid_q;
    assign if_m_axi4_lite.araddr  = addr_q;
    assign if_m_axi4_lite.rready  = rready_q;
endmodule
